// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver
// Purpose  : Holds branch resolutions per ROB slot, releases them when the
//            branch reaches the ROB head, and flushes on a taken branch.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolver #(
    parameter int FLUSH_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [3:0]  br_rob_index,
    input  logic [15:0] br_target,
    input  logic        br_taken,
    input  logic        head_valid,
    input  logic [3:0]  head_index,
    input  logic        head_is_branch,
    output logic        retire_valid,
    output logic [3:0]  retire_index,
    output logic        flush,
    output logic [15:0] redirect_pc,
    output logic        head_wait,
    output logic        dup_error
);

    localparam int             CW          = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [CW-1:0]  C_HOLD_LAST = CW'(FLUSH_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [15:0]    r_resolved;
    logic [15:0]    r_taken;
    logic [15:0]    r_target [16];

    logic           w_idle;
    logic           w_bypass;
    logic           w_head_resolved;
    logic           w_head_taken;
    logic [15:0]    w_head_target;
    logic           w_hit;
    logic           w_flush_now;

    // A resolution arriving this cycle for the head slot is forwarded into the check
    assign w_idle          = (r_state == S_IDLE);
    assign w_bypass        = br_valid && (br_rob_index == head_index);
    assign w_head_resolved = w_bypass || r_resolved[head_index];
    assign w_head_taken    = w_bypass ? br_taken  : r_taken[head_index];
    assign w_head_target   = w_bypass ? br_target : r_target[head_index];
    assign w_hit           = w_idle && head_valid && head_is_branch && w_head_resolved;
    assign w_flush_now     = w_hit && w_head_taken;

    assign head_wait = w_idle && head_valid && head_is_branch && !w_hit && !retire_valid;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_flush_now)    w_state_next = S_RECOVER;
            S_RECOVER: if (r_cnt == '0)    w_state_next = S_IDLE;
            default:                       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_flush_now)
                r_cnt <= C_HOLD_LAST;
            else if (!w_idle && r_cnt != '0)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    // Resolved bits: flush wipes everything; a retire clear beats a same-slot write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resolved <= '0;
            dup_error  <= 1'b0;
        end else begin
            if (w_idle && br_valid && r_resolved[br_rob_index])
                dup_error <= 1'b1;
            if (!w_idle || w_flush_now) begin
                r_resolved <= '0;
            end else begin
                if (br_valid)
                    r_resolved[br_rob_index] <= 1'b1;
                if (w_hit)
                    r_resolved[head_index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken <= '0;
        end else if (w_idle && br_valid) begin
            r_taken[br_rob_index]  <= br_taken;
            r_target[br_rob_index] <= br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_valid <= 1'b0;
            retire_index <= '0;
            flush        <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            retire_valid <= w_hit;
            flush        <= w_flush_now;
            if (w_hit)
                retire_index <= head_index;
            if (w_flush_now)
                redirect_pc <= w_head_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolver
// Purpose  : Vector-table bench; post-edge expectations go through a queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid = 1'b0;
    logic [3:0]  br_rob_index = '0;
    logic [15:0] br_target = '0;
    logic        br_taken = 1'b0;
    logic        head_valid = 1'b0;
    logic [3:0]  head_index = '0;
    logic        head_is_branch = 1'b0;
    logic        retire_valid;
    logic [3:0]  retire_index;
    logic        flush;
    logic [15:0] redirect_pc;
    logic        head_wait;
    logic        dup_error;

    int total = 0;
    int bad   = 0;

    branch_resolver #(.FLUSH_HOLD(2)) dut (
        .clk(clk), .reset(reset),
        .br_valid(br_valid), .br_rob_index(br_rob_index),
        .br_target(br_target), .br_taken(br_taken),
        .head_valid(head_valid), .head_index(head_index),
        .head_is_branch(head_is_branch),
        .retire_valid(retire_valid), .retire_index(retire_index),
        .flush(flush), .redirect_pc(redirect_pc),
        .head_wait(head_wait), .dup_error(dup_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, bv, bt, hv, hb;
        logic [3:0]  bi, hi;
        logic [15:0] tgt;
        logic        e_wait, e_rv, e_fl, e_dup;
        logic [3:0]  e_ri;
        logic [15:0] e_pc;
    } vec_t;

    typedef struct {
        int          row;
        logic        rv, fl, dup;
        logic [3:0]  ri;
        logic [15:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic rst, logic bv, logic [3:0] bi, logic bt, logic [15:0] tgt,
                                logic hv, logic [3:0] hi, logic hb,
                                logic w, logic rv, logic [3:0] ri, logic fl,
                                logic [15:0] pc, logic dup);
        vec_t v;
        v.rst = rst; v.bv = bv; v.bi = bi; v.bt = bt; v.tgt = tgt;
        v.hv = hv; v.hi = hi; v.hb = hb;
        v.e_wait = w; v.e_rv = rv; v.e_ri = ri; v.e_fl = fl; v.e_pc = pc; v.e_dup = dup;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, act, exp);
        end
    endtask

    task automatic check_pending();
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("retire_valid", e.row, {15'd0, retire_valid}, {15'd0, e.rv});
            chk("retire_index", e.row, {12'd0, retire_index}, {12'd0, e.ri});
            chk("flush",        e.row, {15'd0, flush},        {15'd0, e.fl});
            chk("redirect_pc",  e.row, redirect_pc,           e.pc);
            chk("dup_error",    e.row, {15'd0, dup_error},    {15'd0, e.dup});
        end
    endtask

    // Negedge: compare the previous edge's results, drive new inputs, check head_wait
    task automatic step(input vec_t v, input int row);
        exp_t e;
        @(negedge clk);
        check_pending();
        reset = v.rst; br_valid = v.bv; br_rob_index = v.bi; br_taken = v.bt;
        br_target = v.tgt; head_valid = v.hv; head_index = v.hi; head_is_branch = v.hb;
        #1;
        chk("head_wait", row, {15'd0, head_wait}, {15'd0, v.e_wait});
        e.row = row; e.rv = v.e_rv; e.ri = v.e_ri; e.fl = v.e_fl; e.pc = v.e_pc; e.dup = v.e_dup;
        sb.push_back(e);
    endtask

    initial begin
        //                 rst bv bi  bt tgt      hv hi  hb   w rv ri  fl pc       dup
        vecs.push_back(mk(1, 0, 0,  0, 16'h0000, 0, 0,  0,   0, 0, 0,  0, 16'h0000, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 3,  1,   1, 0, 0,  0, 16'h0000, 0)); // 1 head waits
        vecs.push_back(mk(0, 1, 3,  0, 16'h0040, 1, 3,  1,   0, 1, 3,  0, 16'h0000, 0)); // 2 resolve head
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 3,  1,   0, 0, 3,  0, 16'h0000, 0)); // 3 pulse, stale head
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 4,  0,   0, 0, 3,  0, 16'h0000, 0)); // 4 non-branch head
        vecs.push_back(mk(0, 1, 5,  1, 16'h1234, 1, 5,  1,   0, 1, 5,  1, 16'h1234, 0)); // 5 bypass taken
        vecs.push_back(mk(0, 1, 2,  0, 16'h2222, 1, 2,  1,   0, 0, 5,  0, 16'h1234, 0)); // 6 flush cycle, dropped
        vecs.push_back(mk(0, 1, 2,  0, 16'h2222, 1, 2,  1,   0, 0, 5,  0, 16'h1234, 0)); // 7 recover, dropped
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 2,  1,   1, 0, 5,  0, 16'h1234, 0)); // 8 idle, slot 2 empty
        vecs.push_back(mk(0, 1, 2,  0, 16'h0222, 1, 2,  1,   0, 1, 2,  0, 16'h1234, 0)); // 9 fresh write retires
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 2,  1,   0, 0, 2,  0, 16'h1234, 0)); // 10
        vecs.push_back(mk(0, 1, 9,  0, 16'h0900, 1, 10, 0,   0, 0, 2,  0, 16'h1234, 0)); // 11 early slot 9
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0,  0,   0, 0, 2,  0, 16'h1234, 0)); // 12
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0,  0,   0, 0, 2,  0, 16'h1234, 0)); // 13
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0,  0,   0, 0, 2,  0, 16'h1234, 0)); // 14
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 9,  1,   0, 1, 9,  0, 16'h1234, 0)); // 15 head reaches 9
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 9,  1,   0, 0, 9,  0, 16'h1234, 0)); // 16 stale, masked
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 9,  1,   1, 0, 9,  0, 16'h1234, 0)); // 17 no double retire
        vecs.push_back(mk(0, 1, 7,  0, 16'h0700, 0, 0,  0,   0, 0, 9,  0, 16'h1234, 0)); // 18 slot 7 first
        vecs.push_back(mk(0, 1, 7,  0, 16'h0701, 0, 0,  0,   0, 0, 9,  0, 16'h1234, 1)); // 19 duplicate
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 0, 0,  0,   0, 0, 9,  0, 16'h1234, 1)); // 20 sticky
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 7,  1,   0, 1, 7,  0, 16'h1234, 1)); // 21 retire 7
        vecs.push_back(mk(0, 1, 15, 1, 16'hF00F, 0, 0,  0,   0, 0, 7,  0, 16'h1234, 1)); // 22 slot 15 taken
        vecs.push_back(mk(0, 1, 0,  0, 16'h0001, 1, 15, 1,   0, 1, 15, 1, 16'hF00F, 1)); // 23 flush from table
        vecs.push_back(mk(1, 0, 0,  0, 16'h0000, 1, 0,  1,   0, 0, 0,  0, 16'h0000, 0)); // 24 reset in recover
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0,  1,   1, 0, 0,  0, 16'h0000, 0)); // 25 table empty
        vecs.push_back(mk(0, 1, 0,  1, 16'hABCD, 1, 0,  1,   0, 1, 0,  1, 16'hABCD, 0)); // 26 bypass flush
        vecs.push_back(mk(1, 0, 0,  0, 16'h0000, 0, 0,  0,   0, 0, 0,  0, 16'h0000, 0)); // 27 reset in pulse
        vecs.push_back(mk(0, 0, 0,  0, 16'h0000, 1, 0,  1,   1, 0, 0,  0, 16'h0000, 0)); // 28 idle after reset

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], i);

        // Hand sequence: fill every slot not-taken, then walk the head 0..15 across the wrap
        for (int s = 0; s < 16; s++)
            step(mk(0, 1, 4'(s), 0, 16'(s * 3), 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0), 100 + s);
        for (int k = 0; k < 16; k++) begin
            step(mk(0, 0, 0, 0, 16'h0000, 1, 4'(k), 1, 0, 1, 4'(k), 0, 16'h0000, 0), 200 + 2 * k);
            step(mk(0, 0, 0, 0, 16'h0000, 1, 4'(k), 1, 0, 0, 4'(k), 0, 16'h0000, 0), 201 + 2 * k);
        end

        @(negedge clk);
        check_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
